issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_if.sv | 39 +++
 rtl/issue_ctrl.sv | 105 ++++++++++
 tb/tb_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_ctrl_if.sv
//------------------------------------------------------------------------------
// issue_ctrl_if : decoder -> issue -> RS/LSB/ROB handshake bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface issue_ctrl_if #(
    parameter int PAYLOAD_W = 160
);
    logic                 dec_valid_in;
    logic [1:0]           dec_to_lsb_in;
    logic [PAYLOAD_W-1:0] dec_payload_in;
    logic                 rs_full_in;
    logic                 lsb_full_in;
    logic                 rob_full_in;
    logic                 rob_clear_in;
    logic                 fet_stall_out;
    logic                 rs_valid_out;
    logic                 lsb_valid_out;
    logic                 lsb_store_out;
    logic                 rob_issue_out;
    logic [PAYLOAD_W-1:0] payload_out;

    modport master (
        output dec_valid_in, dec_to_lsb_in, dec_payload_in,
        output rs_full_in, lsb_full_in, rob_full_in, rob_clear_in,
        input  fet_stall_out, rs_valid_out, lsb_valid_out, lsb_store_out,
        input  rob_issue_out, payload_out
    );

    modport slave (
        input  dec_valid_in, dec_to_lsb_in, dec_payload_in,
        input  rs_full_in, lsb_full_in, rob_full_in, rob_clear_in,
        output fet_stall_out, rs_valid_out, lsb_valid_out, lsb_store_out,
        output rob_issue_out, payload_out
    );
endinterface

`default_nettype wire

// File: rtl/issue_ctrl.sv
//------------------------------------------------------------------------------
// issue_ctrl : single-entry issue stage dispatching decoded instructions to RS or LSB
// Optional ISSUE_STALL_CNT_EN adds a saturating HOLD-cycle counter. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module issue_ctrl #(
    parameter int PAYLOAD_W = 160
) (
    input  wire logic     clk_in,
    input  wire logic     rst_in,
    input  wire logic     rdy_in,
    issue_ctrl_if.slave   bus
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt_out
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]           state_q,   state_d;
    logic                 tgt_lsb_q, tgt_lsb_d;
    logic                 store_q,   store_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    logic ok_new;
    logic ok_held;
    logic send;

    assign ok_new  = (bus.dec_to_lsb_in[1] ? !bus.lsb_full_in : !bus.rs_full_in) && !bus.rob_full_in;
    assign ok_held = (tgt_lsb_q ? !bus.lsb_full_in : !bus.rs_full_in) && !bus.rob_full_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            tgt_lsb_q <= 1'b0;
            store_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            tgt_lsb_q <= tgt_lsb_d;
            store_q   <= store_d;
            payload_q <= payload_d;
        end
    end

    // A flush wins even while the pipeline is frozen so it can never be lost.
    always_comb begin
        state_d   = state_q;
        tgt_lsb_d = tgt_lsb_q;
        store_d   = store_q;
        payload_d = payload_q;
        if (bus.rob_clear_in) begin
            state_d = ST_IDLE;
        end else if (rdy_in) begin
            case (state_q)
                ST_HOLD: begin
                    if (ok_held) begin
                        state_d = ST_SEND;
                    end
                end
                default: begin
                    if (bus.dec_valid_in) begin
                        tgt_lsb_d = bus.dec_to_lsb_in[1];
                        store_d   = bus.dec_to_lsb_in[0];
                        payload_d = bus.dec_payload_in;
                        state_d   = ok_new ? ST_SEND : ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        send              = (state_q == ST_SEND) && rdy_in;
        bus.rs_valid_out  = send && !tgt_lsb_q;
        bus.lsb_valid_out = send && tgt_lsb_q;
        bus.lsb_store_out = send && tgt_lsb_q && store_q;
        bus.rob_issue_out = send;
        bus.fet_stall_out = (state_q == ST_HOLD) && rdy_in;
        bus.payload_out   = payload_q;
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_HOLD) && rdy_in && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_ctrl.sv
//------------------------------------------------------------------------------
// tb_issue_ctrl : directed + randomized bench for issue_ctrl against a transaction model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_issue_ctrl;
    localparam int PW = 160;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    issue_ctrl_if #(.PAYLOAD_W(PW)) bus ();

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    issue_ctrl #(.PAYLOAD_W(PW)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
`ifdef ISSUE_STALL_CNT_EN
        ,
        .stall_cnt_out (stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: at most one instruction in flight, either waiting for room or due for dispatch.
    bit          m_present;
    bit          m_waiting;
    bit          m_lsb;
    bit          m_store;
    logic [PW-1:0] m_payload;
    longint      m_cnt;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit has_room(input bit to_lsb);
        return (to_lsb ? !bus.lsb_full_in : !bus.rs_full_in) && !bus.rob_full_in;
    endfunction

    task automatic quiet();
        rst                = 1'b0;
        rdy                = 1'b1;
        bus.dec_valid_in   = 1'b0;
        bus.dec_to_lsb_in  = 2'b00;
        bus.rs_full_in     = 1'b0;
        bus.lsb_full_in    = 1'b0;
        bus.rob_full_in    = 1'b0;
        bus.rob_clear_in   = 1'b0;
    endtask

    // Compare all outputs against the model mid-cycle.
    task automatic at_neg();
        bit due;
        @(negedge clk);
        due = m_present && !m_waiting && rdy;
        check("rs_valid",  bus.rs_valid_out,  due && !m_lsb);
        check("lsb_valid", bus.lsb_valid_out, due && m_lsb);
        check("lsb_store", bus.lsb_store_out, due && m_lsb && m_store);
        check("rob_issue", bus.rob_issue_out, due);
        check("fet_stall", bus.fet_stall_out, m_present && m_waiting && rdy);
        if (due) check("payload", bus.payload_out, m_payload);
`ifdef ISSUE_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_cnt[31:0]);
`endif
    endtask

    // Apply this cycle's inputs to the model, then cross the clock edge.
    task automatic adv();
        if (rst) begin
            m_present = 1'b0;
            m_payload = '0;
            m_cnt     = 0;
        end else begin
            if (m_present && m_waiting && rdy && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (bus.rob_clear_in) begin
                m_present = 1'b0;
            end else if (rdy) begin
                if (m_present && m_waiting) begin
                    if (has_room(m_lsb)) m_waiting = 1'b0;
                end else if (bus.dec_valid_in) begin
                    m_present = 1'b1;
                    m_lsb     = bus.dec_to_lsb_in[1];
                    m_store   = bus.dec_to_lsb_in[0];
                    m_payload = bus.dec_payload_in;
                    m_waiting = !has_room(m_lsb);
                end else begin
                    m_present = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        at_neg();
        adv();
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        m_present = 1'b0; m_waiting = 1'b0; m_lsb = 1'b0; m_store = 1'b0;
        m_payload = '0;   m_cnt = 0;
        quiet();
        bus.dec_payload_in = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        adv();
        rst = 1'b0;
        at_neg();
        check("rst_payload", bus.payload_out, '0);
        check("rst_stall",   bus.fet_stall_out, 1'b0);
        adv();

        // Single RS dispatch, latency 1, one cycle wide
        bus.dec_valid_in = 1'b1; bus.dec_to_lsb_in = 2'b00; bus.dec_payload_in = PW'(8'h5A);
        step();
        bus.dec_valid_in = 1'b0;
        at_neg();
        check("t1_rs", bus.rs_valid_out, 1'b1);
        check("t1_rob", bus.rob_issue_out, 1'b1);
        check("t1_pay", bus.payload_out, PW'(8'h5A));
        adv();
        at_neg();
        check("t1_once", bus.rs_valid_out, 1'b0);
        adv();

        // LSB store blocked by a full LSB
        bus.dec_valid_in = 1'b1; bus.dec_to_lsb_in = 2'b11; bus.lsb_full_in = 1'b1;
        bus.dec_payload_in = PW'(16'hBEEF);
        step();
        bus.dec_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.lsb_full_in = 1'b0;
            at_neg();
            check("t2_stall", bus.fet_stall_out, 1'b1);
            adv();
        end
        at_neg();
        check("t2_lsb", bus.lsb_valid_out, 1'b1);
        check("t2_store", bus.lsb_store_out, 1'b1);
        check("t2_nostall", bus.fet_stall_out, 1'b0);
        adv();

        // Back-to-back RS dispatches
        for (int i = 1; i <= 5; i++) begin
            bus.dec_valid_in   = (i <= 4);
            bus.dec_to_lsb_in  = 2'b00;
            bus.dec_payload_in = PW'(i);
            at_neg();
            if (i >= 2) begin
                check("t3_rs", bus.rs_valid_out, 1'b1);
                check("t3_pay", bus.payload_out, PW'(i - 1));
            end
            check("t3_stall", bus.fet_stall_out, 1'b0);
            adv();
        end
        step();

        // Flush while holding, with a competing decode
        bus.dec_valid_in = 1'b1; bus.rs_full_in = 1'b1;
        step();
        bus.rob_clear_in = 1'b1;
        step();
        bus.rob_clear_in = 1'b0; bus.dec_valid_in = 1'b0; bus.rs_full_in = 1'b0;
        at_neg();
        check("t4_stall", bus.fet_stall_out, 1'b0);
        check("t4_rs", bus.rs_valid_out, 1'b0);
        adv();

        // Freeze during SEND
        bus.dec_valid_in = 1'b1; bus.dec_payload_in = PW'(8'h77);
        step();
        bus.dec_valid_in = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            check("t5_frozen", bus.rs_valid_out, 1'b0);
            adv();
        end
        rdy = 1'b1;
        at_neg();
        check("t5_pulse", bus.rs_valid_out, 1'b1);
        check("t5_pay", bus.payload_out, PW'(8'h77));
        adv();
        at_neg();
        check("t5_once", bus.rs_valid_out, 1'b0);
        adv();

`ifdef ISSUE_STALL_CNT_EN
        // Stall counter survives a flush
        do_reset();
        bus.dec_valid_in = 1'b1; bus.rob_full_in = 1'b1;
        step();
        bus.dec_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.rob_clear_in = 1'b1;
        step();
        bus.rob_clear_in = 1'b0; bus.rob_full_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("t6_cnt", stall_cnt, 32'd5);
            adv();
        end
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rdy                = ($urandom_range(0, 99) < 85);
            bus.dec_valid_in   = ($urandom_range(0, 99) < 70);
            bus.dec_to_lsb_in  = 2'($urandom_range(0, 3));
            bus.dec_payload_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
            bus.rs_full_in     = ($urandom_range(0, 99) < 25);
            bus.lsb_full_in    = ($urandom_range(0, 99) < 25);
            bus.rob_full_in    = ($urandom_range(0, 99) < 15);
            bus.rob_clear_in   = rdy && ($urandom_range(0, 99) < 3);
            rst                = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
